// File: rtl/serial_sub32.sv
// serial_sub32: digit-serial subtractor computing a - b - bin, DIGIT bits per clock.
// Start/done handshake; diff/bout/ovf update only on the completing edge.
module serial_sub32 #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1   // must divide WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Operand MSBs captured at start; the operand registers shift them away.
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT:0]   digit_sum;
  logic [WIDTH-1:0] res_shift;
  logic             last_digit;

  // Per-digit datapath: DIGIT+1 bit difference whose MSB is the outgoing borrow.
  always_comb begin
    digit_sum  = {1'b0, a_sh_q[DIGIT-1:0]} - {1'b0, b_sh_q[DIGIT-1:0]}
                 - (DIGIT+1)'(borrow_q);
    res_shift  = (res_q >> DIGIT) | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    last_digit = (cnt_q == CW'(N - 1));
  end

  // Next-state and datapath control; every register holds unless updated.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = bin;
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
          cnt_d    = '0;
          state_d  = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> DIGIT;
        b_sh_d   = b_sh_q >> DIGIT;
        res_d    = res_shift;
        borrow_d = digit_sum[DIGIT];
        cnt_d    = cnt_q + CW'(1);
        if (last_digit) begin
          diff_d  = res_shift;
          bout_d  = digit_sum[DIGIT];
          ovf_d   = (a_msb_q != b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/serial_sub32.md
# serial_sub32

Multi-cycle, digit-serial 32-bit subtractor with start/done handshake. Computes a − b − bin and produces difference, borrow-out and signed-overflow. It processes DIGIT bits per clock, trading latency for area. It is the inverse-direction companion to the team's 32-bit ripple adder and takes the same operand and carry-style interface plus a handshake.

## Interface
- WIDTH, 32, operand width in bits
- DIGIT, 1, bits processed per clock; must divide WIDTH (legal: 1, 2, 4, 8, 16, 32)
- clk  input  1  system clock, rising-edge
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- start  input  1  request; sampled on rising clk edge when busy=0
- a  input  WIDTH  minuend; sampled with start
- b  input  WIDTH  subtrahend; sampled with start
- bin  input  1  borrow-in; sampled with start
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  (a − b − bin) mod 2^WIDTH
- bout  output  1  borrow-out: 1 iff a < b + bin (unsigned)
- ovf  output  1  signed overflow: a[MSB]≠b[MSB] and diff[MSB]≠a[MSB]

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE/DONE with start=1 at an edge:
  - latch a, b and bin into operand shift registers; the borrow register takes bin
  - clear the digit counter; go to RUN
- IDLE with start=0: stay. DONE with start=0: go to IDLE.
- RUN, each edge:
  - subtract the low DIGIT bits of the operand registers with the current borrow
  - shift the result digit into the high end of the result shift register; shift the operands right by DIGIT
  - update the borrow register; increment the counter
  - after the N-th digit (N = WIDTH/DIGIT), load diff, bout and ovf from the internal registers, assert done, and go to DONE
- busy = (state == RUN). done = (state == DONE).
- diff, bout and ovf change only on the completing edge. They hold the previous result during RUN and until the next completion.
- start while busy=1 is ignored: no effect on the operation in flight, and it is not queued.
- start in the DONE cycle is accepted (back-to-back): the next edge enters RUN, so done and busy never overlap.
- Width rules:
  - the per-digit difference is computed DIGIT+1 bits wide; its MSB is the borrow into the next digit
  - the final borrow is bout
  - ovf uses the sampled operand MSBs (held in a dedicated register, since the operand registers shift) and the final diff MSB
- Boundary conditions:
  - a=b, bin=0 → diff=0, bout=0
  - a=0, b=2^WIDTH−1, bin=1 → diff=0, bout=1
  - bin=1 with b all-ones wraps correctly; no special case

## Timing
- Reset (asserted asynchronously, at any time including mid-RUN):
  - state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0
  - internal registers cleared; the operation in progress is discarded
- After rst_n deasserts, the first edge can accept start.
- Latency, with start sampled at edge k:
  - busy=1 from after edge k to edge k+N
  - done=1 and results valid for exactly the cycle after edge k+N
- DIGIT=1: N=32 clocks. DIGIT=4: N=8. DIGIT=32: N=1.
- Throughput with back-to-back starts: one result per N+1 cycles.
- Inputs a, b and bin may change freely after the sampling edge.

## Test plan
- Reset: hold rst_n=0, then release with start=0 → busy=0, done=0, diff=0, bout=0, ovf=0; no done pulse within 100 cycles. Pulse rst_n low asynchronously (between edges) → outputs clear immediately.
- Basic: a=5, b=3, bin=0, DIGIT=1 → done exactly 33rd cycle after start edge (edge k+32); diff=2, bout=0, ovf=0. Repeat with DIGIT=4 → done after edge k+8, same result.
- Borrow/wrap: a=0, b=1, bin=0 → diff=0xFFFFFFFF, bout=1, ovf=0. Then a=0x80000000, b=1, bin=0 → diff=0x7FFFFFFF, bout=0, ovf=1.
- Full-width vector: a=0xFFC00FFC, b=0xFFFFF003, bin=1 → diff=0xFFC01FF8, bout=1, ovf=0. Compare against a reference model over 1000 random a, b, bin, for DIGIT ∈ {1, 4, 32}.
- Handshake:
  - start pulses while busy=1 (change a/b) → ignored; the result matches the first operands
  - start asserted in the DONE cycle → busy rises the next cycle; the second result follows N+1 cycles after the first
  - diff holds its old value throughout RUN
- Reset mid-operation: assert rst_n=0 at RUN digit 10 → all outputs 0 immediately; after release, no done appears until a new start is sampled.
